// File: rtl/alu181_pkg.sv
// Shared constants for the alu_181 slice: function-select codes and output reset values.
package alu181_pkg;

    // Arithmetic (M=0) select codes
    localparam logic [3:0] S_A       = 4'b0000;
    localparam logic [3:0] S_A_OR_B  = 4'b0001;
    localparam logic [3:0] S_A_OR_NB = 4'b0010;
    localparam logic [3:0] S_MINUS1  = 4'b0011;
    localparam logic [3:0] S_SUB     = 4'b0110;
    localparam logic [3:0] S_ADD     = 4'b1001;
    localparam logic [3:0] S_DOUBLE  = 4'b1100;
    localparam logic [3:0] S_DEC     = 4'b1111;

    // Logic (M=1) select codes
    localparam logic [3:0] S_NOT_A   = 4'b0000;
    localparam logic [3:0] S_ZERO    = 4'b0011;
    localparam logic [3:0] S_XOR     = 4'b0110;
    localparam logic [3:0] S_XNOR    = 4'b1001;
    localparam logic [3:0] S_PASS_B  = 4'b1010;
    localparam logic [3:0] S_AND     = 4'b1011;
    localparam logic [3:0] S_ONES    = 4'b1100;
    localparam logic [3:0] S_PASS_A  = 4'b1111;

    localparam logic [3:0] F_RST     = 4'h0;
    localparam logic       C4_RST    = 1'b1;
    localparam logic       AEQB_RST  = 1'b0;
    localparam logic       P_RST     = 1'b1;
    localparam logic       G_RST     = 1'b1;

endpackage

// File: rtl/alu181_core.sv
// Combinational 74181 slice: X/Y terms, sum or logic result, lookahead carry and A=B flag.
module alu181_core
    import alu181_pkg::*;
(
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    input  logic       M,
    input  logic [3:0] S,
    output logic [3:0] F,
    output logic       C4,
    output logic       AequB,
    output logic       P,
    output logic       G
);

    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] sum;
    logic       gh;
    logic       ph;

    // x is the per-bit propagate, y the per-bit generate; y always implies x
    assign x = A | (B & {4{S[0]}}) | (~B & {4{S[1]}});
    assign y = (A & ~B & {4{S[2]}}) | (A & B & {4{S[3]}});

    assign sum = x + y + {3'b000, ~C0};

    assign gh = y[3] | (x[3] & y[2]) | (x[3] & x[2] & y[1]) | (x[3] & x[2] & x[1] & y[0]);
    assign ph = &x;

    assign F     = M ? ~(x ^ y) : sum;
    assign C4    = ~(gh | (ph & ~C0));
    assign G     = ~gh;
    assign P     = ~ph;
    assign AequB = &F;

endmodule

// File: rtl/alu_181.sv
// Top of the 4-bit 74181-style ALU slice: core plus output register stage.
// Define ALU181_COMB_OUT_EN to bypass the registers for combinational cascading.
module alu_181
    import alu181_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    input  logic       M,
    input  logic [3:0] S,
    output logic [3:0] F,
    output logic       C4,
    output logic       AequB,
    output logic       P,
    output logic       G
);

    logic [3:0] fP0;
    logic       c4P0;
    logic       aequbP0;
    logic       pP0;
    logic       gP0;

    alu181_core uCore (
        .A     (A),
        .B     (B),
        .C0    (C0),
        .M     (M),
        .S     (S),
        .F     (fP0),
        .C4    (c4P0),
        .AequB (aequbP0),
        .P     (pP0),
        .G     (gP0)
    );

`ifdef ALU181_COMB_OUT_EN
    assign F     = fP0;
    assign C4    = c4P0;
    assign AequB = aequbP0;
    assign P     = pP0;
    assign G     = gP0;
`else
    logic [3:0] fP1;
    logic       c4P1;
    logic       aequbP1;
    logic       pP1;
    logic       gP1;

    // p0 -> p1: output register stage, reset wins over new inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            fP1     <= F_RST;
            c4P1    <= C4_RST;
            aequbP1 <= AEQB_RST;
            pP1     <= P_RST;
            gP1     <= G_RST;
        end else begin
            fP1     <= fP0;
            c4P1    <= c4P0;
            aequbP1 <= aequbP0;
            pP1     <= pP0;
            gP1     <= gP0;
        end
    end

    assign F     = fP1;
    assign C4    = c4P1;
    assign AequB = aequbP1;
    assign P     = pP1;
    assign G     = gP1;
`endif

endmodule

// File: tb/tb_alu_181.sv
// Directed self-checking bench for alu_181; a second slice cascades off the first's C4.
module tb_alu_181;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] aLo, bLo, aHi, bHi, s;
    logic       c0, m;
    logic [3:0] fLo, fHi;
    logic       c4Lo, c4Hi, eqLo, eqHi, pLo, pHi, gLo, gHi;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    alu_181 dutLo (
        .clk(clk), .rst(rst), .A(aLo), .B(bLo), .C0(c0), .M(m), .S(s),
        .F(fLo), .C4(c4Lo), .AequB(eqLo), .P(pLo), .G(gLo)
    );

    alu_181 dutHi (
        .clk(clk), .rst(rst), .A(aHi), .B(bHi), .C0(c4Lo), .M(m), .S(s),
        .F(fHi), .C4(c4Hi), .AequB(eqHi), .P(pHi), .G(gHi)
    );

    // Reference: packs {F, C4, P, G, AequB}; carries come from a 5-bit sum
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic cin, input logic mode, input logic [3:0] sel);
        logic [3:0] x, y, f;
        logic [4:0] sumC, sumNoC;
        for (int i = 0; i < 4; i++) begin
            x[i] = a[i] | (sel[0] & b[i]) | (sel[1] & ~b[i]);
            y[i] = (sel[2] & a[i] & ~b[i]) | (sel[3] & a[i] & b[i]);
        end
        sumC   = {1'b0, x} + {1'b0, y} + (cin ? 5'd0 : 5'd1);
        sumNoC = {1'b0, x} + {1'b0, y};
        f = mode ? ~(x ^ y) : sumC[3:0];
        return {f, ~sumC[4], ~(&x), ~sumNoC[4], &f};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
`ifdef ALU181_COMB_OUT_EN
        #2;
`else
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic mode, input logic [3:0] sel);
        aLo = a; bLo = b; c0 = cin; m = mode; s = sel;
    endtask

    logic [7:0] prev;

    initial begin
        rst = 1'b1;
        aLo = 4'h0; bLo = 4'h0; aHi = 4'h0; bHi = 4'h0; s = 4'h0; c0 = 1'b1; m = 1'b0;
        step();
        step();
`ifndef ALU181_COMB_OUT_EN
        check("reset_state", {fLo, c4Lo, pLo, gLo, eqLo}, 8'b0000_1110);
`endif
        rst = 1'b0;

        // Arithmetic
        drive(4'h5, 4'h7, 1'b1, 1'b0, 4'b1001); step();
        check("add_5_7", {fLo, c4Lo}, {3'b000, 4'hC, 1'b1});
        drive(4'h5, 4'h7, 1'b0, 1'b0, 4'b1001); step();
        check("add_5_7_cin", {fLo, c4Lo}, {3'b000, 4'hD, 1'b1});
        drive(4'h5, 4'h7, 1'b0, 1'b0, 4'b0110); step();
        check("sub_5_7", {fLo, c4Lo}, {3'b000, 4'hE, 1'b1});
        drive(4'h9, 4'h9, 1'b1, 1'b0, 4'b0110); step();
        check("aeqb_9_9", {fLo, eqLo}, {3'b000, 4'hF, 1'b1});

        // Logic
        drive(4'h5, 4'h7, 1'b1, 1'b1, 4'b0110); step();
        check("logic_xor", {4'h0, fLo}, 8'h02);
        drive(4'h5, 4'h7, 1'b1, 1'b1, 4'b0000); step();
        check("logic_nota", {4'h0, fLo}, 8'h0A);
        drive(4'h5, 4'h7, 1'b1, 1'b1, 4'b1100); step();
        check("logic_ones", {fLo, eqLo}, {3'b000, 4'hF, 1'b1});
        drive(4'h5, 4'h7, 1'b1, 1'b1, 4'b0011); step();
        check("logic_zero", {fLo, eqLo}, {3'b000, 4'h0, 1'b0});

        // 8-bit cascade 0x65 + 0xA7 = 0x10C
        drive(4'h5, 4'h7, 1'b1, 1'b0, 4'b1001); aHi = 4'h6; bHi = 4'hA;
        step();
        step();
        check("cascade_f", {fHi, fLo}, 8'h0C);
        check("cascade_c8", {7'd0, c4Hi}, 8'h00);

`ifndef ALU181_COMB_OUT_EN
        // Reset mid-operation, then recovery one edge after release
        drive(4'h5, 4'h7, 1'b1, 1'b0, 4'b1001);
        rst = 1'b1; step();
        check("reset_mid", {fLo, c4Lo, pLo, gLo, eqLo}, 8'b0000_1110);
        rst = 1'b0; #2;
        check("reset_hold", {fLo, c4Lo, pLo, gLo, eqLo}, 8'b0000_1110);
        step();
        check("reset_recover", {fLo, c4Lo}, {3'b000, 4'hC, 1'b1});
`endif

        // Full select sweep for A=5, B=7 with one-edge lag check
        prev = model(4'h5, 4'h7, 1'b1, 1'b0, 4'b1001);
        for (int k = 0; k < 64; k++) begin
            drive(4'h5, 4'h7, k[0], k[1], k[5:2]);
`ifndef ALU181_COMB_OUT_EN
            #2;
            check($sformatf("lag_s%0d_m%0d_c%0d", k[5:2], k[1], k[0]),
                  {fLo, c4Lo, pLo, gLo, eqLo}, prev);
`endif
            step();
            prev = model(4'h5, 4'h7, k[0], k[1], k[5:2]);
            check($sformatf("sweep_s%0d_m%0d_c%0d", k[5:2], k[1], k[0]),
                  {fLo, c4Lo, pLo, gLo, eqLo}, prev);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
